// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and memory.
// One outstanding request at a time. The master holds bus_req and the command
// fields steady until the slave pulses bus_ack. Read data is valid in the ack cycle.
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit.
// Formats stores into byte enables and replicated lanes. Extracts and extends
// load data. Stalls the pipeline while a bus access is in flight. Reports
// misaligned, illegal and timed-out accesses as a one-cycle access_err pulse.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [2:0]                funct3,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic                      stall,
    output logic [31:0]               rdata,
    output logic                      load_valid,
    output logic                      access_err,
    load_store_unit_if.master         bus
);
    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];

    typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  funct3_reg;
    logic [1:0]  lane_reg;
    logic [7:0]  timer_reg;
    logic [31:0] rdata_reg;

    // Request decode. Both strobes set means a store.
    logic req_start, is_store, illegal, misaligned, accept, timeout_hit;
    assign req_start   = (mem_read == 1'b1) || (mem_write == 1'b1);
    assign is_store    = (mem_write == 1'b1);
    assign illegal     = is_store ? (funct3 >= 3'b011)
                                  : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    assign misaligned  = (funct3[1:0] == 2'b01 && addr[0]) ||
                         (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign accept      = req_start && !illegal && !misaligned;
    assign timeout_hit = (timer_reg + 8'd1) == TIMEOUT_LIM;

    // Store formatting per byte lane: enable and replicated data.
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign be_fmt[gi] = (funct3[1:0] == 2'b00) ? (addr[1:0] == LANE) :
                            (funct3[1:0] == 2'b01) ? (addr[1] == LANE[1]) : 1'b1;
        assign wdata_fmt[8*gi +: 8] = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                                      (funct3[1:0] == 2'b01) ? wdata[8*(gi%2) +: 8] :
                                                               wdata[8*gi +: 8];
    end

    // Load extraction from the returned word, using the captured lane and width.
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    always_comb begin
        byte_sel = bus.bus_rdata[7:0];
        case (lane_reg)
            2'd1:    byte_sel = bus.bus_rdata[15:8];
            2'd2:    byte_sel = bus.bus_rdata[23:16];
            2'd3:    byte_sel = bus.bus_rdata[31:24];
            default: byte_sel = bus.bus_rdata[7:0];
        endcase
        half_sel = lane_reg[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (funct3_reg)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = bus.bus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state and pipeline-facing outputs.
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        load_valid = 1'b0;
        access_err = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_start) begin
                    stall      = 1'b1;
                    state_next = accept ? BUS : ERR;
                end
            end
            BUS: begin
                stall = 1'b1;
                if (bus.bus_ack)      state_next = DONE;
                else if (timeout_hit) state_next = ERR;
            end
            DONE: begin
                load_valid = !bus.bus_we;
                state_next = IDLE;
            end
            ERR: begin
                access_err = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus command, timeout counter and load result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
            funct3_reg    <= '0;
            lane_reg      <= '0;
            timer_reg     <= '0;
            rdata_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= is_store;
                        bus.bus_addr  <= {addr[31:2], 2'b00};
                        bus.bus_wdata <= wdata_fmt;
                        bus.bus_be    <= is_store ? be_fmt : 4'b1111;
                        funct3_reg    <= funct3;
                        lane_reg      <= addr[1:0];
                        timer_reg     <= '0;
                    end
                end
                BUS: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (!bus.bus_we) rdata_reg <= load_ext;
                    end else if (timeout_hit) begin
                        bus.bus_req <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata = rdata_reg;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Executes the data-memory access requested by the main control decoder (mem_read / mem_write) on a single-outstanding request/acknowledge bus. It formats stores (byte enables, lane replication), extracts and extends loads, and stalls the pipeline until the access completes. It sits in the MEM stage between the ALU result / rs2 operands and the data memory, and reports misaligned, illegal and timed-out accesses.

## Interface
- TIMEOUT_CYCLES, 16: BUS-state cycles without bus_ack before the access is aborted (≥1, ≤255)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  load request from main control
- mem_write  in  1  store request from main control
- funct3  in  3  instr[14:12]: width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- addr  in  32  effective byte address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  hold the pipeline (combinational)
- rdata  out  32  extended load result (registered)
- load_valid  out  1  one-cycle pulse: rdata valid
- access_err  out  1  one-cycle pulse: misaligned, illegal funct3 or timeout
- bus_req  out  1  bus request (registered)
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_ack  in  1  access complete; bus_rdata valid in same cycle
- bus_rdata  in  32  read word

## Operation
- States: IDLE, BUS, DONE, ERR.
- Request = (mem_read==1 or mem_write==1); both asserted is treated as a store. Only logic 1 starts an access; undecoded opcodes must reach this block as 0.
- IDLE, no request: stall=0, stay.
- IDLE, request, legal and aligned: stall=1; at the edge register bus_we/addr/wdata/be, load funct3 and addr[1:0], clear timeout counter, set bus_req, go BUS.
- IDLE, request, illegal or misaligned: stall=1; no bus activity; go ERR.
  - Illegal: loads funct3 ∈ {011,110,111}; stores funct3 ≥ 011.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00. Byte accesses never misalign.
- BUS: stall=1, bus_req=1, all bus outputs stable.
  - bus_ack=1: clear bus_req; for loads register extended rdata; go DONE.
  - else counter+1; counter reaching TIMEOUT_CYCLES: clear bus_req, go ERR (late ack ignored).
- DONE: stall=0; load_valid=1 for loads only; go IDLE. Request inputs in DONE are ignored (they belong to the instruction retiring this edge).
- ERR: stall=0; access_err=1; rdata unchanged; go IDLE.
- Store formatting: SB be=4'b0001<<addr[1:0], bus_wdata={4{wdata[7:0]}}; SH be=addr[1]?1100:0011, bus_wdata={2{wdata[15:0]}}; SW be=1111, bus_wdata=wdata.
- Load extraction: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW passthrough. Loads drive bus_be=1111.
- bus_ack outside BUS ignored.

## Timing
- Reset (async, rst_n=0): state IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_be, rdata, load_valid, access_err, timeout counter all 0; stall=0. Reset during BUS drops bus_req immediately; the access is abandoned.
- Access with ack after k BUS cycles (k≥1): stall high for 1+k cycles, then DONE cycle stall=0.
- Minimum access (ack in first BUS cycle): stall 2 cycles; load_valid and rdata in cycle 3.
- Error path: 1 stall cycle, access_err in next cycle.
- Timeout: bus_req high exactly TIMEOUT_CYCLES cycles, access_err the cycle after it drops.
- Back-to-back accesses: next request accepted in the IDLE cycle following DONE/ERR.

## Test plan
- Reset mid-access: BUS state, rst_n low -> bus_req=0 same cycle, all outputs 0; after release, load of 0x100 runs normally.
- SB addr=0x1003, wdata=0xAABBCCDD, ack after 3 cycles -> bus_addr=0x1000, be=1000, bus_wdata=0xDDDDDDDD, bus_we=1, stall 4 cycles, no load_valid.
- LB addr=0x2001, bus_rdata=0x12_80_34_56 ack immediate -> rdata=0xFFFFFF34?  no: lane1=0x34 -> rdata=0x00000034; LB addr=0x2002 -> 0xFFFFFF80; LHU addr=0x2002 -> 0x00001280; LW -> 0x12803456; load_valid one pulse each.
- Misaligned LW addr=0x3002 and LH addr=0x3001; illegal load funct3=011 -> no bus_req, stall 1 cycle, access_err 1 pulse.
- TIMEOUT_CYCLES=4, store with no ack -> bus_req high 4 cycles, then access_err; ack arriving afterward ignored.
- Back-to-back SW 0x40 then LW 0x40 with ack in first BUS cycle -> each stalls 2 cycles, exactly one bus_req per access, second returns stored word.
